stream_demux4: RTL and testbench

- 1-to-4 valid/ready stream demultiplexer with packet awareness. It is the distributing counterpart of the select-one-of-N multiplexers.
- Steers one producer stream, such as a memory or bus response stream, to one of four consumers, chosen by a 2-bit select.
- Each output has a one-entry registered slot, so input-to-output latency is one cycle and consumers drain independently.
- Select is locked for the duration of a multi-beat packet, delimited by in_last.

---
 rtl/stream_demux4.sv | 92 +++++++++
 tb/tb_stream_demux4.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux4.sv
// 1-to-4 valid/ready stream demultiplexer with one registered beat slot per destination.
// The destination is locked from a packet's first beat until the beat carrying in_last_i.
//  state     | meaning
//  ST_IDLE   | between packets; destination follows in_sel_i
//  ST_LOCKED | mid-packet; destination held in lock_sel_q
module stream_demux4 #(
   parameter int width = 32
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic [width-1:0]      in_data_i,
   input  logic [1:0]            in_sel_i,
   input  logic                  in_last_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [3:0][width-1:0] out_data_o,
   output logic [3:0]            out_last_o,
   output logic [3:0]            out_valid_o,
   input  logic [3:0]            out_ready_i,
   output logic                  busy_o,
   output logic [1:0]            cur_sel_o
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [1:0]            lock_sel_q, lock_sel_d;
   logic [3:0]            valid_q, valid_d;
   logic [3:0]            last_q, last_d;
   logic [3:0][width-1:0] data_q, data_d;
   logic [1:0]            sel;
   logic                  accept;

   assign sel        = (state_q == ST_LOCKED) ? lock_sel_q : in_sel_i;
   // Ready looks only at the selected slot, so a stalled consumer never blocks the others.
   assign in_ready_o = ~valid_q[sel] | out_ready_i[sel];
   assign accept     = in_valid_i & in_ready_o;

   always_comb begin
      valid_d = valid_q & ~out_ready_i;
      last_d  = last_q;
      data_d  = data_q;
      if (accept) begin
         valid_d[sel] = 1'b1;
         last_d[sel]  = in_last_i;
         data_d[sel]  = in_data_i;
      end
   end

   always_comb begin
      state_d    = state_q;
      lock_sel_d = lock_sel_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && !in_last_i) begin
               state_d    = ST_LOCKED;
               lock_sel_d = in_sel_i;
            end
         end
         ST_LOCKED: begin
            if (accept && in_last_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         lock_sel_q <= 2'd0;
         valid_q    <= 4'd0;
         last_q     <= 4'd0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         lock_sel_q <= lock_sel_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         data_q     <= data_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_last_o  = last_q;
   assign out_data_o  = data_q;
   assign busy_o      = (state_q == ST_LOCKED);
   assign cur_sel_o   = sel;

endmodule

// File: tb/tb_stream_demux4.sv
// Self-checking bench for stream_demux4: vector table, directed corner sequences,
// and randomized traffic against a per-destination beat scoreboard.
module tb_stream_demux4;
   localparam int W = 32;

   logic                clock = 1'b0;
   logic                reset;
   logic [W-1:0]        in_data;
   logic [1:0]          in_sel;
   logic                in_last;
   logic                in_valid;
   logic                in_ready;
   logic [3:0][W-1:0]   out_data;
   logic [3:0]          out_last;
   logic [3:0]          out_valid;
   logic [3:0]          out_ready;
   logic                busy;
   logic [1:0]          cur_sel;

   int checks   = 0;
   int failures = 0;

   stream_demux4 #(.width(W)) dut (
      .clock_i     (clock),
      .reset_i     (reset),
      .in_data_i   (in_data),
      .in_sel_i    (in_sel),
      .in_last_i   (in_last),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .out_data_o  (out_data),
      .out_last_o  (out_last),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .busy_o      (busy),
      .cur_sel_o   (cur_sel)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic beat(input logic [1:0] s, input logic [W-1:0] d, input logic l);
      in_valid = 1'b1;
      in_sel   = s;
      in_data  = d;
      in_last  = l;
   endtask

   typedef struct {
      logic [1:0]   sel;
      logic [W-1:0] data;
      logic         last;
      logic [3:0]   exp_valid;
      logic [1:0]   exp_slot;
      logic         exp_busy;
   } vec_t;

   vec_t vecs[5];

   logic [W:0] q[4][$];
   logic       m_busy;
   logic [1:0] m_dest;
   logic [1:0] dest;
   logic       exp_rdy;

   initial begin
      vecs[0] = '{2'd2, 32'hDEADBEEF, 1'b1, 4'b0100, 2'd2, 1'b0};
      vecs[1] = '{2'd0, 32'h00000001, 1'b0, 4'b0001, 2'd0, 1'b1};
      vecs[2] = '{2'd3, 32'h00000002, 1'b1, 4'b0001, 2'd0, 1'b0};
      vecs[3] = '{2'd1, 32'h00000003, 1'b1, 4'b0010, 2'd1, 1'b0};
      vecs[4] = '{2'd3, 32'h00000004, 1'b0, 4'b1000, 2'd3, 1'b1};

      reset = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_last = 1'b0;
      in_data = '0; out_ready = 4'b1111;
      @(negedge clock); @(negedge clock);
      chk("rst_valid", out_valid, 4'b0000);
      chk("rst_last", out_last, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cur_sel", cur_sel, 2'd0);
      for (int i = 0; i < 4; i++) chk("rst_data", out_data[i], '0);
      reset = 1'b0;

      // Vector table: consecutive beats with all consumers ready.
      for (int i = 0; i < 5; i++) begin
         beat(vecs[i].sel, vecs[i].data, vecs[i].last);
         #1 chk("vec_in_ready", in_ready, 1'b1);
         @(negedge clock);
         chk("vec_valid", out_valid, vecs[i].exp_valid);
         chk("vec_data", out_data[vecs[i].exp_slot], vecs[i].data);
         chk("vec_last", out_last[vecs[i].exp_slot], vecs[i].last);
         chk("vec_busy", busy, vecs[i].exp_busy);
      end
      beat(2'd0, 32'h5, 1'b1);
      #1 chk("vec_tail_cur_sel", cur_sel, 2'd3);
      @(negedge clock);
      chk("vec_tail_valid", out_valid, 4'b1000);
      chk("vec_tail_busy", busy, 1'b0);
      in_valid = 1'b0;
      @(negedge clock);
      chk("vec_drain_valid", out_valid, 4'b0000);

      // Packet lock across changing in_sel.
      beat(2'd1, 32'h11, 1'b0);
      #1 chk("pkt_cur_sel1", cur_sel, 2'd1);
      @(negedge clock);
      chk("pkt_valid1", out_valid, 4'b0010);
      chk("pkt_data1", out_data[1], 32'h11);
      chk("pkt_busy1", busy, 1'b1);
      beat(2'd3, 32'h22, 1'b0);
      #1 chk("pkt_cur_sel2", cur_sel, 2'd1);
      @(negedge clock);
      chk("pkt_valid2", out_valid, 4'b0010);
      chk("pkt_data2", out_data[1], 32'h22);
      chk("pkt_busy2", busy, 1'b1);
      beat(2'd0, 32'h33, 1'b1);
      @(negedge clock);
      chk("pkt_valid3", out_valid, 4'b0010);
      chk("pkt_data3", out_data[1], 32'h33);
      chk("pkt_last3", out_last[1], 1'b1);
      chk("pkt_busy3", busy, 1'b0);
      in_valid = 1'b0;
      @(negedge clock);
      chk("pkt_drain", out_valid, 4'b0000);

      // Back-pressure on destination 0.
      out_ready = 4'b1110;
      beat(2'd0, 32'hA1, 1'b1);
      #1 chk("bp_ready1", in_ready, 1'b1);
      @(negedge clock);
      chk("bp_valid1", out_valid, 4'b0001);
      beat(2'd0, 32'hA2, 1'b1);
      for (int i = 0; i < 2; i++) begin
         #1 chk("bp_stall_ready", in_ready, 1'b0);
         @(negedge clock);
         chk("bp_stall_valid", out_valid, 4'b0001);
         chk("bp_stall_data", out_data[0], 32'hA1);
      end
      out_ready = 4'b1111;
      #1 chk("bp_release_ready", in_ready, 1'b1);
      @(negedge clock);
      chk("bp_reload_valid", out_valid, 4'b0001);
      chk("bp_reload_data", out_data[0], 32'hA2);
      in_valid = 1'b0;
      @(negedge clock);
      chk("bp_drain", out_valid, 4'b0000);

      // Independence: slot 0 stalled while slot 3 flows.
      out_ready = 4'b1110;
      beat(2'd0, 32'hB0, 1'b1);
      @(negedge clock);
      beat(2'd3, 32'hB3, 1'b1);
      #1 chk("ind_ready", in_ready, 1'b1);
      @(negedge clock);
      chk("ind_valid", out_valid, 4'b1001);
      chk("ind_data3", out_data[3], 32'hB3);
      in_valid = 1'b0;
      @(negedge clock);
      chk("ind_valid2", out_valid, 4'b0001);
      chk("ind_data0", out_data[0], 32'hB0);
      out_ready = 4'b1111;
      @(negedge clock);
      chk("ind_drain", out_valid, 4'b0000);

      // Asynchronous reset mid-packet.
      out_ready = 4'b0000;
      beat(2'd1, 32'hC1, 1'b1);
      @(negedge clock);
      beat(2'd2, 32'hC2, 1'b0);
      @(negedge clock);
      in_valid = 1'b0;
      chk("rm_pre_valid", out_valid, 4'b0110);
      chk("rm_pre_busy", busy, 1'b1);
      #2 reset = 1'b1;
      #1 chk("rm_async_valid", out_valid, 4'b0000);
      chk("rm_async_busy", busy, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      out_ready = 4'b1111;
      beat(2'd0, 32'hD0, 1'b1);
      #1 chk("rm_cur_sel", cur_sel, 2'd0);
      @(negedge clock);
      chk("rm_post_valid", out_valid, 4'b0001);
      chk("rm_post_data", out_data[0], 32'hD0);
      in_valid = 1'b0;
      @(negedge clock);

      // Idle gap inside a packet.
      beat(2'd2, 32'hE1, 1'b0);
      @(negedge clock);
      chk("gap_busy0", busy, 1'b1);
      in_valid = 1'b0;
      in_sel   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("gap_busy", busy, 1'b1);
         chk("gap_valid", out_valid, 4'b0000);
      end
      beat(2'd0, 32'hE2, 1'b1);
      #1 chk("gap_cur_sel", cur_sel, 2'd2);
      @(negedge clock);
      chk("gap_valid_end", out_valid, 4'b0100);
      chk("gap_data_end", out_data[2], 32'hE2);
      chk("gap_busy_end", busy, 1'b0);
      in_valid = 1'b0;
      @(negedge clock);

      // Randomized traffic: every accepted beat queued per destination, popped on handshake.
      m_busy = 1'b0;
      m_dest = 2'd0;
      for (int n = 0; n < 2000; n++) begin
         for (int d = 0; d < 4; d++) begin
            chk("rnd_valid", out_valid[d], q[d].size() != 0);
            if (q[d].size() != 0 && out_valid[d]) begin
               chk("rnd_data", out_data[d], q[d][0][W-1:0]);
               chk("rnd_last", out_last[d], q[d][0][W]);
            end
         end
         chk("rnd_busy", busy, m_busy);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_sel    = 2'($urandom);
         in_last   = ($urandom_range(0, 2) == 0);
         in_data   = $urandom;
         out_ready = 4'($urandom);
         #1;
         dest    = m_busy ? m_dest : in_sel;
         exp_rdy = (q[dest].size() == 0) || out_ready[dest];
         chk("rnd_cur_sel", cur_sel, dest);
         chk("rnd_in_ready", in_ready, exp_rdy);
         for (int d = 0; d < 4; d++)
            if (q[d].size() != 0 && out_ready[d]) void'(q[d].pop_front());
         if (in_valid && exp_rdy) begin
            q[dest].push_back({in_last, in_data});
            if (!m_busy && !in_last) begin
               m_busy = 1'b1;
               m_dest = in_sel;
            end else if (m_busy && in_last) begin
               m_busy = 1'b0;
            end
         end
         @(negedge clock);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
